silife_demo_loader: RTL and testbench

// Parametrised demo-pattern loader/stepper for the SiLife cell grid. After reset it writes one
// of NUM_PATTERNS built-in patterns into the grid row by row, then issues periodic step pulses.

---
 rtl/silife_demo_pkg.sv | 18 +
 rtl/silife_pattern_rom.sv | 66 ++++++
 rtl/silife_demo_loader.sv | 157 +++++++++++++++
 tb/tb_silife_demo_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/silife_demo_pkg.sv
// Shared types, default geometry and width helper for the SiLife demo loader.
package silife_demo_pkg;

    localparam int unsigned DEF_ROWS = 32;
    localparam int unsigned DEF_COLS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Index width for a range of n values, never below one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/silife_pattern_rom.sv
// Built-in demo patterns: combinational (pattern, row) -> row word, MSB is column 0.
module silife_pattern_rom
    import silife_demo_pkg::*;
#(
    parameter int unsigned ROWS         = DEF_ROWS,
    parameter int unsigned COLS         = DEF_COLS,
    parameter int unsigned NUM_PATTERNS = 2,
    localparam int unsigned ROW_W       = width_of(ROWS),
    localparam int unsigned PAT_W       = width_of(NUM_PATTERNS)
) (
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [ROW_W-1:0] i_row,
    output logic [COLS-1:0]  o_word
);

    // Pattern art is drawn in the leftmost eight columns; wider grids pad with dead cells.
    function automatic logic [7:0] base_word(input int p, input int r);
        logic [7:0] w;
        w = 8'h00;
        case (p)
            0: begin                              // glider
                case (r)
                    0:       w = 8'h40;
                    1:       w = 8'h20;
                    2:       w = 8'hE0;
                    default: w = 8'h00;
                endcase
            end
            1: begin                              // block + blinker
                case (r)
                    0:       w = 8'hC0;
                    1:       w = 8'hC7;
                    3:       w = 8'h18;
                    default: w = 8'h00;
                endcase
            end
            2: begin                              // r-pentomino
                case (r)
                    0:       w = 8'h30;
                    1:       w = 8'h60;
                    2:       w = 8'h20;
                    default: w = 8'h00;
                endcase
            end
            default: w = 8'(r * 37 + p * 11) ^ 8'hA5;  // dense filler for extra slots
        endcase
        return w;
    endfunction

    logic [7:0] w_base;

    // Look up the eight-column art for the requested pattern and row.
    always_comb begin
        w_base = base_word(32'(i_pattern), 32'(i_row));
    end

    // Place column c of the art at word bit COLS-1-c.
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
        if (gc < 8) begin : g_art
            assign o_word[COLS-1-gc] = w_base[7-gc];
        end else begin : g_pad
            assign o_word[COLS-1-gc] = 1'b0;
        end
    end

endmodule

// File: rtl/silife_demo_loader.sv
// Demo loader/stepper: writes a built-in pattern into the grid, then paces generation steps.
module silife_demo_loader
    import silife_demo_pkg::*;
#(
    parameter int unsigned ROWS         = DEF_ROWS,
    parameter int unsigned COLS         = DEF_COLS,
    parameter int unsigned NUM_PATTERNS = 2,
    parameter int unsigned STEP_PERIOD  = 4_000_000,
    localparam int unsigned ROW_W       = width_of(ROWS),
    localparam int unsigned PAT_W       = width_of(NUM_PATTERNS),
    localparam int unsigned CNT_W       = width_of(STEP_PERIOD)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [PAT_W-1:0] i_pattern_select,
    input  logic             i_reload,
    input  logic             i_run,
    input  logic             i_single_step,
    output logic [ROW_W-1:0] o_row_select,
    output logic [COLS-1:0]  o_cells,
    output logic             o_wr_en,
    output logic             o_step,
    output logic             o_busy,
    output logic             o_load_done
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);

    state_e           r_state;
    logic [ROW_W-1:0] r_row;
    logic [CNT_W-1:0] r_cnt;
    logic [PAT_W-1:0] r_pat;
    logic             r_wr_en;
    logic             r_step;
    logic             r_busy;
    logic             r_load_done;

    state_e           w_state_nxt;
    logic [ROW_W-1:0] w_row_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PAT_W-1:0] w_pat_nxt;
    logic             w_wr_en_nxt;
    logic             w_step_nxt;
    logic             w_busy_nxt;
    logic             w_load_done_nxt;

    logic [PAT_W-1:0] w_sel_mapped;
    logic             w_start_load;
    logic [COLS-1:0]  w_rom_word;

    // Out-of-range selections fall back to pattern 0 so they never retrigger a reload.
    assign w_sel_mapped = (32'(i_pattern_select) < NUM_PATTERNS) ? i_pattern_select : '0;

    // IDLE always starts a load; LOAD/RUN restart on reload or a new selection.
    assign w_start_load = (r_state == ST_IDLE) || i_reload || (w_sel_mapped != r_pat);

    // Next-state, counter and output-strobe decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_cnt_nxt       = r_cnt;
        w_pat_nxt       = r_pat;
        w_wr_en_nxt     = 1'b0;
        w_step_nxt      = 1'b0;
        w_load_done_nxt = 1'b0;

        if (i_en) begin
            if (w_start_load) begin
                w_state_nxt = ST_LOAD;
                w_pat_nxt   = w_sel_mapped;
                w_row_nxt   = '0;
                w_cnt_nxt   = '0;
                w_wr_en_nxt = 1'b1;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (!r_wr_en) begin
                            // Re-present the held row after an enable gap.
                            w_wr_en_nxt = 1'b1;
                        end else if (r_row == ROW_LAST) begin
                            w_load_done_nxt = 1'b1;
                            w_cnt_nxt       = '0;
                            w_state_nxt     = ST_RUN;
                        end else begin
                            w_row_nxt   = r_row + ROW_W'(1);
                            w_wr_en_nxt = 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (i_run) begin
                            if (r_cnt == CNT_LAST) begin
                                w_step_nxt = 1'b1;
                                w_cnt_nxt  = '0;
                            end else begin
                                w_cnt_nxt = r_cnt + CNT_W'(1);
                            end
                        end else if (i_single_step) begin
                            w_step_nxt = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end

        w_busy_nxt = (w_state_nxt != ST_RUN);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_cnt       <= '0;
            r_pat       <= '0;
            r_wr_en     <= 1'b0;
            r_step      <= 1'b0;
            r_busy      <= 1'b1;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pat       <= w_pat_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_step      <= w_step_nxt;
            r_busy      <= w_busy_nxt;
            r_load_done <= w_load_done_nxt;
        end
    end

    silife_pattern_rom #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .NUM_PATTERNS (NUM_PATTERNS)
    ) u_rom (
        .i_pattern (r_pat),
        .i_row     (r_row),
        .o_word    (w_rom_word)
    );

    // cells[i] is column i, i.e. ROM word bit COLS-1-i.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_cells
        assign o_cells[gi] = w_rom_word[COLS-1-gi];
    end

    assign o_row_select = r_row;
    assign o_wr_en      = r_wr_en;
    assign o_step       = r_step;
    assign o_busy       = r_busy;
    assign o_load_done  = r_load_done;

endmodule

// File: tb/tb_silife_demo_loader.sv
// Self-checking bench for silife_demo_loader (ROWS=4, COLS=8, STEP_PERIOD=5).
module tb_silife_demo_loader;

    localparam int ROWS = 4;
    localparam int NP   = 2;
    localparam int SP   = 5;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       en     = 1'b0;
    logic       sel    = 1'b0;
    logic       reload = 1'b0;
    logic       run    = 1'b0;
    logic       ss     = 1'b0;
    logic [1:0] sel_b  = 2'd3;

    logic [1:0] row;
    logic [7:0] cells;
    logic       wr, step, busy, done;
    logic [1:0] b_row;
    logic [7:0] b_cells;
    logic       b_wr, b_step, b_busy, b_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_phase;   // 0 idle, 1 load, 2 run
    int m_row, m_cnt, m_pat;
    bit m_wr, m_step, m_done, m_busy;

    always #5 clk = ~clk;

    silife_demo_loader #(.ROWS(4), .COLS(8), .NUM_PATTERNS(2), .STEP_PERIOD(5)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_pattern_select(sel), .i_reload(reload),
        .i_run(run), .i_single_step(ss), .o_row_select(row), .o_cells(cells), .o_wr_en(wr),
        .o_step(step), .o_busy(busy), .o_load_done(done)
    );

    silife_demo_loader #(.ROWS(4), .COLS(8), .NUM_PATTERNS(3), .STEP_PERIOD(5)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_pattern_select(sel_b), .i_reload(reload),
        .i_run(run), .i_single_step(ss), .o_row_select(b_row), .o_cells(b_cells), .o_wr_en(b_wr),
        .o_step(b_step), .o_busy(b_busy), .o_load_done(b_done)
    );

    // Expected pattern art, column 0 in the MSB.
    function automatic logic [7:0] rom(input int p, input int r);
        logic [7:0] t0 [4];
        logic [7:0] t1 [4];
        t0 = '{8'h40, 8'h20, 8'hE0, 8'h00};
        t1 = '{8'hC0, 8'hC7, 8'h00, 8'h18};
        return (p == 1) ? t1[r] : t0[r];
    endfunction

    // Grid cells are column-indexed: cells[i] = column i.
    function automatic logic [7:0] exp_cells(input int p, input int r);
        logic [7:0] w;
        w = rom(p, r);
        return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
    endfunction

    // Behavioural model: one clock edge of the loader's rules.
    task automatic model_edge();
        bit was_wr;
        int msel;
        was_wr = m_wr;
        if (rst) begin
            m_phase = 0; m_row = 0; m_cnt = 0; m_pat = 0;
            m_wr = 0; m_step = 0; m_done = 0; m_busy = 1;
        end else if (!en) begin
            m_wr = 0; m_step = 0; m_done = 0;
        end else begin
            m_wr = 0; m_step = 0; m_done = 0;
            msel = (int'(sel) < NP) ? int'(sel) : 0;
            if (m_phase == 0 || reload || msel != m_pat) begin
                m_phase = 1; m_pat = msel; m_row = 0; m_cnt = 0; m_wr = 1;
            end else if (m_phase == 1) begin
                if (!was_wr) m_wr = 1;
                else if (m_row == ROWS - 1) begin
                    m_done = 1; m_cnt = 0; m_phase = 2;
                end else begin
                    m_row = m_row + 1; m_wr = 1;
                end
            end else if (run) begin
                m_cnt = (m_cnt + 1) % SP;
                m_step = (m_cnt == 0);
            end else if (ss) begin
                m_step = 1;
            end
            m_busy = (m_phase != 2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; reload = 1'b0; ss = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; sel = 1'b0; run = 1'b1;
        rst = 1'b1;
        tick(); tick();
        n_tests++;
        if (row !== 2'd0 || wr !== 1'b0 || step !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: row=%0d wr=%0b step=%0b done=%0b busy=%0b, want 0 0 0 0 1",
                     row, wr, step, done, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_and_steps();
        for (int k = 0; k < ROWS; k++) begin
            tick();
            n_tests++;
            if (wr !== 1'b1 || row !== 2'(k) || cells !== exp_cells(0, k) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL load_row%0d: wr=%0b row=%0d cells=%h busy=%0b, want 1 %0d %h 1",
                         k, wr, row, cells, busy, k, exp_cells(0, k));
            end
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || wr !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: done=%0b wr=%0b busy=%0b, want 1 0 0", done, wr, busy);
        end
        for (int c = 1; c <= 3 * SP; c++) begin
            tick();
            n_tests++;
            if (step !== ((c % SP) == 0) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL step_period c=%0d: step=%0b done=%0b, want %0b 0",
                         c, step, done, (c % SP) == 0);
            end
        end
    endtask

    task automatic test_switch_midload();
        sel = 1'b0; run = 1'b1;
        do_reset();
        tick(); tick(); tick();
        n_tests++;
        if (row !== 2'd2 || wr !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_pre: row=%0d wr=%0b, want 2 1", row, wr);
        end
        sel = 1'b1;
        for (int k = 0; k < ROWS; k++) begin
            tick();
            n_tests++;
            if (wr !== 1'b1 || row !== 2'(k) || cells !== exp_cells(1, k)) begin
                n_fail++;
                $display("FAIL switch_row%0d: wr=%0b row=%0d cells=%h, want 1 %0d %h",
                         k, wr, row, cells, k, exp_cells(1, k));
            end
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || wr !== 1'b0) begin
            n_fail++;
            $display("FAIL switch_done: done=%0b wr=%0b, want 1 0", done, wr);
        end
    endtask

    task automatic test_pause_single_step();
        sel = 1'b0; run = 1'b0;
        do_reset();
        repeat (ROWS + 1) tick();
        for (int c = 0; c < 20; c++) begin
            tick();
            n_tests++;
            if (step !== 1'b0) begin
                n_fail++;
                $display("FAIL paused_step c=%0d: step=%0b, want 0", c, step);
            end
        end
        ss = 1'b1;
        tick();
        ss = 1'b0;
        n_tests++;
        if (step !== 1'b1) begin
            n_fail++;
            $display("FAIL single_step: step=%0b, want 1", step);
        end
        tick();
        n_tests++;
        if (step !== 1'b0) begin
            n_fail++;
            $display("FAIL single_step_once: step=%0b, want 0", step);
        end
        run = 1'b1;
        for (int c = 1; c <= SP; c++) begin
            tick();
            n_tests++;
            if (step !== (c == SP)) begin
                n_fail++;
                $display("FAIL resume c=%0d: step=%0b, want %0b", c, step, c == SP);
            end
        end
    endtask

    task automatic test_reload_vs_step();
        run = 1'b0; ss = 1'b1; reload = 1'b1;
        tick();
        ss = 1'b0; reload = 1'b0;
        n_tests++;
        if (step !== 1'b0 || wr !== 1'b1 || row !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_wins: step=%0b wr=%0b row=%0d busy=%0b, want 0 1 0 1",
                     step, wr, row, busy);
        end
    endtask

    task automatic test_en_freeze();
        sel = 1'b0; run = 1'b1;
        do_reset();
        tick(); tick();
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (wr !== 1'b0 || row !== 2'd1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL en_freeze c=%0d: wr=%0b row=%0d done=%0b, want 0 1 0", c, wr, row, done);
            end
        end
        en = 1'b1;
        for (int k = 1; k < ROWS; k++) begin
            tick();
            n_tests++;
            if (wr !== 1'b1 || row !== 2'(k) || cells !== exp_cells(0, k)) begin
                n_fail++;
                $display("FAIL en_resume row%0d: wr=%0b row=%0d cells=%h, want 1 %0d %h",
                         k, wr, row, cells, k, exp_cells(0, k));
            end
        end
        tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL en_resume_done: done=%0b, want 1", done);
        end
    endtask

    task automatic test_pattern_map();
        sel_b = 2'd3;
        do_reset();
        for (int k = 0; k < ROWS; k++) begin
            tick();
            n_tests++;
            if (b_wr !== 1'b1 || b_row !== 2'(k) || b_cells !== exp_cells(0, k)) begin
                n_fail++;
                $display("FAIL map_row%0d: wr=%0b row=%0d cells=%h, want 1 %0d %h",
                         k, b_wr, b_row, b_cells, k, exp_cells(0, k));
            end
        end
        tick();
        tick();
        n_tests++;
        if (b_wr !== 1'b0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL map_settled: wr=%0b busy=%0b, want 0 0", b_wr, b_busy);
        end
    endtask

    task automatic test_reset_midrun();
        sel = 1'b1; run = 1'b1;
        do_reset();
        repeat (ROWS + 3) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (row !== 2'd0 || wr !== 1'b0 || step !== 1'b0 || done !== 1'b0 || busy !== 1'b1 ||
            cells !== exp_cells(0, 0)) begin
            n_fail++;
            $display("FAIL reset_midrun: row=%0d wr=%0b step=%0b done=%0b busy=%0b cells=%h, want 0 0 0 0 1 %h",
                     row, wr, step, done, busy, cells, exp_cells(0, 0));
        end
        repeat (SP) begin
            tick();
            n_tests++;
            if (step !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold_step: step=%0b, want 0", step);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst    = ($urandom_range(0, 199) == 0);
            en     = ($urandom_range(0, 9) != 0);
            reload = ($urandom_range(0, 29) == 0);
            ss     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) run = ~run;
            if ($urandom_range(0, 39) == 0) sel = ~sel;
            tick();
            n_tests++;
            if (row !== 2'(m_row) || cells !== exp_cells(m_pat, m_row) || wr !== m_wr ||
                step !== m_step || busy !== m_busy || done !== m_done) begin
                n_fail++;
                $display("FAIL random c=%0d: row=%0d cells=%h wr=%0b step=%0b busy=%0b done=%0b, want %0d %h %0b %0b %0b %0b",
                         c, row, cells, wr, step, busy, done,
                         m_row, exp_cells(m_pat, m_row), m_wr, m_step, m_busy, m_done);
            end
            n_tests++;
            if ((step && busy) || (step && wr)) begin
                n_fail++;
                $display("FAIL random_excl c=%0d: step=%0b busy=%0b wr=%0b, want step exclusive",
                         c, step, busy, wr);
            end
        end
        rst = 1'b0; reload = 1'b0; ss = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_and_steps();
        test_switch_midload();
        test_pause_single_step();
        test_reload_vs_step();
        test_en_freeze();
        test_pattern_map();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
